// File: rtl/control_riesgos.sv
// control_riesgos
// Hazard and stall controller for a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
// Drives the enable/flush pins of the pipeline registers, the PC redirect select
// and the rs/rt forwarding selects. It handles load-use bubbles, EX-resolved
// branch/jr redirects and multi-cycle data-memory waits with a timeout.
//
// Ports
//   clk, reset                    clock (rising edge), async active-high reset
//   id_rs, id_rt, id_uses_rt      source operands of the instruction in ID
//   ex_mem_read, ex_write_reg     lw in EX and its destination
//   ex_redirect                   taken branch / jr resolved in EX
//   mem_reg_write, mem_write_reg  MEM-stage register write
//   mem_access, dmem_ack          MEM-stage lw/sw and data-memory done pulse
//   wb_reg_write, wb_write_reg    WB-stage register write
//   pc_en, pc_sel                 PC load enable / take EX redirect target
//   if_id_en, if_id_flush         IF/ID enable / load NOP
//   id_ex_flush                   ID/EX loads NOP
//   ex_mem_en                     ID/EX and EX/MEM enable
//   mem_wb_bubble                 MEM/WB loads control = 0
//   memAdelant_rs/rt              forward EX/MEM result to rs/rt
//   wbAdelant_rs/rt               forward MEM/WB data to rs/rt
//   mem_err                       sticky memory-timeout flag
//   stall_cycles                  saturating count of cycles with pc_en = 0
//
// state    | meaning
// RUN      | normal flow; memory wait > redirect > load-use evaluated here
// LOAD_USE | the single cycle after a load-use bubble; no second bubble
// MEM_WAIT | pipeline frozen waiting for dmem_ack or timeout
//
// Control outputs are decoded from state and the current inputs because a
// memory wait or a redirect has to act in the very cycle it is seen. They are
// forced to their reset values while reset is high.

module control_riesgos #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             ex_redirect,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_write_reg,
    input  logic             mem_access,
    input  logic             dmem_ack,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_write_reg,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic             memAdelant_rs,
    output logic             memAdelant_rt,
    output logic             wbAdelant_rs,
    output logic             wbAdelant_rt,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, LOAD_USE, MEM_WAIT} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;      // down-counter, 0 = timeout reached
    logic       load_use;
    logic       mem_stall_req;
    logic       wait_done;
    logic       timeout;
    logic       mem_fwd_rs, mem_fwd_rt;

    assign load_use = ex_mem_read && (ex_write_reg != '0) &&
                      ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
    assign mem_stall_req = mem_access && !dmem_ack;
    assign wait_done     = dmem_ack || (wait_cnt == 8'd0);
    assign timeout       = (state == MEM_WAIT) && !dmem_ack && (wait_cnt == 8'd0);

    // Forwarding: register 0 never forwards, MEM has priority over WB.
    assign mem_fwd_rs = mem_reg_write && (mem_write_reg == id_rs) && (id_rs != '0);
    assign mem_fwd_rt = mem_reg_write && (mem_write_reg == id_rt) && (id_rt != '0);
    assign memAdelant_rs = !reset && mem_fwd_rs;
    assign memAdelant_rt = !reset && mem_fwd_rt;
    assign wbAdelant_rs  = !reset && !mem_fwd_rs && wb_reg_write &&
                           (wb_write_reg == id_rs) && (id_rs != '0);
    assign wbAdelant_rt  = !reset && !mem_fwd_rt && wb_reg_write &&
                           (wb_write_reg == id_rt) && (id_rt != '0);

    always_comb begin
        pc_en         = 1'b1;
        pc_sel        = 1'b0;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        state_nxt     = RUN;

        // The release cycle of MEM_WAIT is evaluated like RUN, so a redirect
        // held by the frozen EX stage is serviced there.
        if (((state == MEM_WAIT) && !wait_done) ||
            ((state != MEM_WAIT) && mem_stall_req)) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            state_nxt     = MEM_WAIT;
        end else if (ex_redirect) begin
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if ((state != LOAD_USE) && load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            state_nxt   = LOAD_USE;
        end

        if (reset) begin
            pc_en         = 1'b0;
            pc_sel        = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            state_nxt     = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            // The entry cycle already counts as one frozen cycle.
            if (state != MEM_WAIT)
                wait_cnt <= 8'(MEM_TIMEOUT - 1);
            else if (wait_cnt != 8'd0)
                wait_cnt <= wait_cnt - 8'd1;
            if (timeout)
                mem_err <= 1'b1;
            if (!pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_control_riesgos.sv
module tb_control_riesgos;

    localparam int REG_W = 5;
    localparam int T     = 15;
    localparam int CNT_W = 6;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_write_reg = '0;
    logic [REG_W-1:0] mem_write_reg = '0, wb_write_reg = '0;
    logic             id_uses_rt = 0, ex_mem_read = 0, ex_redirect = 0;
    logic             mem_reg_write = 0, mem_access = 0, dmem_ack = 0, wb_reg_write = 0;
    logic             pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush, ex_mem_en;
    logic             mem_wb_bubble, memAdelant_rs, memAdelant_rt, wbAdelant_rs, wbAdelant_rt;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    control_riesgos #(.REG_W(REG_W), .MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg), .ex_redirect(ex_redirect),
        .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .mem_access(mem_access), .dmem_ack(dmem_ack),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble),
        .memAdelant_rs(memAdelant_rs), .memAdelant_rt(memAdelant_rt),
        .wbAdelant_rs(wbAdelant_rs), .wbAdelant_rt(wbAdelant_rt),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a wait is described by how many frozen cycles it has
    // accumulated so far; a bubble remembers that the previous cycle stalled
    // for a load so the same lw cannot stall twice.
    bit waiting = 0, after_bub = 0, err = 0;
    int frozen = 0, stalls = 0;
    bit m_freeze, m_redir, m_bub, m_timeout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every DUT output against what the rules demand this cycle.
    task automatic eval();
        bit lu, mf_rs, mf_rt, e_pc_en, e_pc_sel, e_ifen, e_iff, e_idf, e_exen, e_bub;
        bit e_wf_rs, e_wf_rt;
        if (reset) begin
            chk("rst_pc_en", pc_en, 0);           chk("rst_pc_sel", pc_sel, 0);
            chk("rst_if_id_en", if_id_en, 0);     chk("rst_if_id_flush", if_id_flush, 1);
            chk("rst_id_ex_flush", id_ex_flush, 1); chk("rst_ex_mem_en", ex_mem_en, 0);
            chk("rst_bubble", mem_wb_bubble, 1);
            chk("rst_fwd", {memAdelant_rs, memAdelant_rt, wbAdelant_rs, wbAdelant_rt}, 0);
            chk("rst_mem_err", mem_err, 0);       chk("rst_stalls", stall_cycles, 0);
            m_freeze = 0; m_redir = 0; m_bub = 0; m_timeout = 0;
            return;
        end
        lu = ex_mem_read && ex_write_reg != 0 &&
             (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt));
        mf_rs = mem_reg_write && mem_write_reg == id_rs && id_rs != 0;
        mf_rt = mem_reg_write && mem_write_reg == id_rt && id_rt != 0;
        e_wf_rs = !mf_rs && wb_reg_write && wb_write_reg == id_rs && id_rs != 0;
        e_wf_rt = !mf_rt && wb_reg_write && wb_write_reg == id_rt && id_rt != 0;
        m_freeze = 0; m_redir = 0; m_bub = 0; m_timeout = 0;
        if (waiting) m_freeze = !dmem_ack && frozen < T;
        else         m_freeze = mem_access && !dmem_ack;
        if (!m_freeze) begin
            m_timeout = waiting && !dmem_ack;
            if (ex_redirect)          m_redir = 1;
            else if (lu && !after_bub) m_bub = 1;
        end
        e_pc_en  = !(m_freeze || m_bub);
        e_ifen   = e_pc_en;
        e_exen   = !m_freeze;
        e_bub    = m_freeze;
        e_pc_sel = m_redir;
        e_iff    = m_redir;
        e_idf    = m_redir || m_bub;
        chk("pc_en", pc_en, e_pc_en);             chk("pc_sel", pc_sel, e_pc_sel);
        chk("if_id_en", if_id_en, e_ifen);        chk("if_id_flush", if_id_flush, e_iff);
        chk("id_ex_flush", id_ex_flush, e_idf);   chk("ex_mem_en", ex_mem_en, e_exen);
        chk("mem_wb_bubble", mem_wb_bubble, e_bub);
        chk("memAdelant_rs", memAdelant_rs, mf_rs); chk("memAdelant_rt", memAdelant_rt, mf_rt);
        chk("wbAdelant_rs", wbAdelant_rs, e_wf_rs); chk("wbAdelant_rt", wbAdelant_rt, e_wf_rt);
        chk("mem_err", mem_err, err);             chk("stall_cycles", stall_cycles, stalls);
    endtask

    // Advances the model across the coming clock edge, then waits for the
    // next falling edge where the bench drives new inputs.
    task automatic adv();
        if (reset) begin
            waiting = 0; after_bub = 0; err = 0; frozen = 0; stalls = 0;
        end else begin
            if (m_freeze) begin
                if (waiting) frozen++;
                else begin waiting = 1; frozen = 1; end
            end else waiting = 0;
            if (m_timeout) err = 1;
            after_bub = m_bub;
            if ((m_freeze || m_bub) && stalls < SAT) stalls++;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_write_reg = 0;
        ex_redirect = 0; mem_reg_write = 0; mem_write_reg = 0; mem_access = 0;
        dmem_ack = 0; wb_reg_write = 0; wb_write_reg = 0;
    endtask

    initial begin
        int lows;
        int drought;
        // Reset with matching forward inputs: selects must still read 0.
        id_rs = 1; mem_reg_write = 1; mem_write_reg = 1;
        @(negedge clk);
        #1; eval(); adv();
        reset = 0; idle_inputs();

        // addi 1 then add 8,1,1: both operands from MEM, no stall.
        id_rs = 1; id_rt = 1; id_uses_rt = 1; mem_reg_write = 1; mem_write_reg = 1;
        wb_reg_write = 1; wb_write_reg = 1;
        #1; eval();
        chk("t1_mem_fwd", {memAdelant_rs, memAdelant_rt}, 2'b11);
        chk("t1_wb_fwd", {wbAdelant_rs, wbAdelant_rt}, 2'b00);
        chk("t1_pc_en", pc_en, 1);
        adv(); idle_inputs();

        // lw 7 then add 6,7,7: one bubble, then forward from MEM.
        ex_mem_read = 1; ex_write_reg = 7; id_rs = 7; id_rt = 7; id_uses_rt = 1;
        #1; eval();
        chk("t2_pc_en", pc_en, 0); chk("t2_id_ex_flush", id_ex_flush, 1);
        adv();
        mem_reg_write = 1; mem_write_reg = 7;   // EX still shows the lw: no second bubble
        #1; eval();
        chk("t2_pc_en_after", pc_en, 1); chk("t2_fwd", memAdelant_rs, 1);
        adv(); idle_inputs();

        // jr resolved in EX: one redirect cycle.
        ex_redirect = 1;
        #1; eval();
        chk("t3_redirect", {pc_sel, if_id_flush, id_ex_flush, pc_en}, 4'b1111);
        adv(); ex_redirect = 0;
        #1; eval();
        chk("t3_after", {pc_sel, if_id_flush, id_ex_flush}, 3'b000);
        adv();

        // sw acknowledged after 3 cycles.
        mem_access = 1; lows = 0;
        for (int i = 0; i < 3; i++) begin
            #1; eval(); if (!pc_en) lows++; adv();
        end
        dmem_ack = 1;
        #1; eval(); chk("t4_release", pc_en, 1); adv();
        idle_inputs();
        #1; eval();
        chk("t4_lows", lows, 3); chk("t4_stalls", stall_cycles, 4); chk("t4_err", mem_err, 0);
        adv();

        // No ack at all: timeout after T frozen cycles.
        mem_access = 1; lows = 0;
        for (int i = 0; i < 40; i++) begin
            #1; eval();
            if (pc_en) break;
            lows++;
            adv();
            if (i == 39) chk("t5_release_timeout", 0, 1);
        end
        adv(); idle_inputs();
        #1; eval();
        chk("t5_lows", lows, T); chk("t5_err", mem_err, 1); chk("t5_stalls", stall_cycles, 19);
        adv();

        // Reset in the middle of a wait.
        mem_access = 1;
        #1; eval(); adv();
        #1; eval();
        #3; reset = 1; #1;
        eval();
        chk("t6_pc_en", pc_en, 0); chk("t6_stalls", stall_cycles, 0); chk("t6_err", mem_err, 0);
        adv();
        reset = 0; idle_inputs();

        // Randomized traffic against the model.
        drought = 0;
        for (int c = 0; c < 1500; c++) begin
            id_rs         = REG_W'($urandom_range(0, 3));
            id_rt         = REG_W'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom_range(0, 1));
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            ex_write_reg  = REG_W'($urandom_range(0, 3));
            ex_redirect   = ($urandom_range(0, 5) == 0);
            mem_reg_write = 1'($urandom_range(0, 1));
            mem_write_reg = REG_W'($urandom_range(0, 3));
            wb_reg_write  = 1'($urandom_range(0, 1));
            wb_write_reg  = REG_W'($urandom_range(0, 3));
            mem_access    = waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
            if (drought == 0 && $urandom_range(0, 60) == 0) drought = 20;
            if (drought > 0) begin dmem_ack = 0; drought--; end
            else dmem_ack = ($urandom_range(0, 2) == 0);
            #1; eval(); adv();
        end
        idle_inputs();
        #1; eval();
        chk("sat_stalls", stall_cycles, SAT);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
